// File: rtl/josh_pkg.sv
// Shared definitions for the J.O.S.H. Jump controller: state set, debug codes,
// colour constants and the default frame period.
package josh_pkg;

    // 60 Hz frames from the 50 MHz board clock
    localparam int FRAME_TICKS_DEFAULT = 833_333;

    // Colour constants used by the draw engine (erase paints the background)
    localparam logic [2:0] COLOUR_BG       = 3'b000;
    localparam logic [2:0] COLOUR_PLAYER   = 3'b010;
    localparam logic [2:0] COLOUR_OBSTACLE = 3'b100;

    // Nine sequencer states need four bits internally
    typedef enum logic [3:0] {
        S_MENU,
        S_MENU_WAIT,
        S_WAIT_FRAME,
        S_ERASE,
        S_UPDATE,
        S_CHECK,
        S_DRAW,
        S_GAMEOVER,
        S_OVER_WAIT
    } state_t;

    // 3-bit debug codes shown on LEDR. The release-wait after game over is
    // reported as game over, since to the player it is still that screen.
    localparam logic [2:0] DBG_MENU       = 3'd0;
    localparam logic [2:0] DBG_MENU_WAIT  = 3'd1;
    localparam logic [2:0] DBG_WAIT_FRAME = 3'd2;
    localparam logic [2:0] DBG_ERASE      = 3'd3;
    localparam logic [2:0] DBG_UPDATE     = 3'd4;
    localparam logic [2:0] DBG_CHECK      = 3'd5;
    localparam logic [2:0] DBG_DRAW       = 3'd6;
    localparam logic [2:0] DBG_GAMEOVER   = 3'd7;

    function automatic logic [2:0] state_code(input state_t s);
        logic [2:0] code;
        code = DBG_MENU;
        case (s)
            S_MENU:       code = DBG_MENU;
            S_MENU_WAIT:  code = DBG_MENU_WAIT;
            S_WAIT_FRAME: code = DBG_WAIT_FRAME;
            S_ERASE:      code = DBG_ERASE;
            S_UPDATE:     code = DBG_UPDATE;
            S_CHECK:      code = DBG_CHECK;
            S_DRAW:       code = DBG_DRAW;
            S_GAMEOVER:   code = DBG_GAMEOVER;
            S_OVER_WAIT:  code = DBG_GAMEOVER;
            default:      code = DBG_MENU;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame timer: counts clk cycles while enabled and emits a one-cycle tick
// on the last count of each frame, then wraps.
module frame_tick_gen #(
    parameter int FRAME_TICKS = 833_333
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_TICKS - 1);

    logic [CW-1:0] ctr_reg;

    assign tick = en && (ctr_reg == LAST);

    // Counter: cleared on reset or start, advances only while enabled
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            ctr_reg <= '0;
        end else if (en) begin
            ctr_reg <= tick ? '0 : ctr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/game_frame_sequencer.sv
// Top-level game controller: menu / game / game-over flow, and per-frame
// sequencing of the shared draw engine (erase all, update, check, redraw).
module game_frame_sequencer
    import josh_pkg::*;
#(
    parameter int FRAME_TICKS = FRAME_TICKS_DEFAULT,
    parameter int N_OBJ       = 4,
    parameter int SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic               collision,
    input  logic               draw_done,
    output logic               draw_req,
    output logic               draw_erase,
    output logic [3:0]         draw_sel,
    output logic               update_en,
    output logic               clear_game,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic               overrun,
    output logic [2:0]         state
);

    localparam logic [3:0]         LAST_OBJ  = 4'(N_OBJ - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_t state_reg;
    logic   tick;
    logic   timer_en;
    logic   timer_clr;

    // Timer runs everywhere except the menu; it restarts on the start edge
    assign timer_en  = (state_reg != S_MENU) && (state_reg != S_MENU_WAIT);
    assign timer_clr = (state_reg == S_MENU_WAIT) && !go;

    frame_tick_gen #(
        .FRAME_TICKS (FRAME_TICKS)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (timer_en),
        .clr   (timer_clr),
        .tick  (tick)
    );

    assign state = state_code(state_reg);

    // Sequencer FSM with registered outputs, object loop and score counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_MENU;
            draw_req   <= 1'b0;
            draw_erase <= 1'b0;
            draw_sel   <= 4'd0;
            update_en  <= 1'b0;
            clear_game <= 1'b0;
            score      <= '0;
            game_over  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            clear_game <= 1'b0;
            update_en  <= 1'b0;

            // A tick outside the idle wait is dropped, but remembered
            if (tick && (state_reg != S_WAIT_FRAME)) begin
                overrun <= 1'b1;
            end

            case (state_reg)
                S_MENU: begin
                    if (go) state_reg <= S_MENU_WAIT;
                end
                S_MENU_WAIT: begin
                    if (!go) begin
                        clear_game <= 1'b1;
                        score      <= '0;
                        state_reg  <= S_WAIT_FRAME;
                    end
                end
                S_WAIT_FRAME: begin
                    if (tick) begin
                        draw_sel   <= 4'd0;
                        draw_erase <= 1'b1;
                        state_reg  <= S_ERASE;
                    end
                end
                S_ERASE, S_DRAW: begin
                    // Idle cycle -> request; hold request until the engine answers
                    if (!draw_req) begin
                        draw_req <= 1'b1;
                    end else if (draw_done) begin
                        draw_req <= 1'b0;
                        draw_sel <= draw_sel + 4'd1;
                        if (draw_sel == LAST_OBJ) begin
                            if (state_reg == S_ERASE) begin
                                update_en <= 1'b1;
                                state_reg <= S_UPDATE;
                            end else begin
                                state_reg <= S_WAIT_FRAME;
                            end
                        end
                    end
                end
                S_UPDATE: begin
                    state_reg <= S_CHECK;
                end
                S_CHECK: begin
                    if (collision) begin
                        game_over <= 1'b1;
                        state_reg <= S_GAMEOVER;
                    end else begin
                        if (score != SCORE_MAX) score <= score + 1'b1;
                        draw_sel   <= 4'd0;
                        draw_erase <= 1'b0;
                        state_reg  <= S_DRAW;
                    end
                end
                S_GAMEOVER: begin
                    if (go) state_reg <= S_OVER_WAIT;
                end
                S_OVER_WAIT: begin
                    if (!go) begin
                        game_over <= 1'b0;
                        state_reg <= S_MENU;
                    end
                end
                default: begin
                    state_reg <= S_MENU;
                end
            endcase
        end
    end

endmodule
